instr_mem_ctrl: RTL and testbench
=================================

# instr_mem_ctrl

Parametrised instruction memory with a synchronous, pipelined fetch port, a program-load write port and a hardware clear sweep. It sits between the fetch stage and the program loader and replaces the earlier combinational-read instruction ROM. The block adds a req/valid handshake, a selectable read latency, out-of-range fault reporting and a clear FSM that zeroes every word.

## Interface
Parameters:
- DATA_W, 32, instruction word width
- ADDR_W, 16, word-address width
- DEPTH, 256, number of words; must satisfy DEPTH ≤ 2^ADDR_W
- READ_LAT, 1, fetch latency in cycles; legal values are 1 or 2

Ports:
- clk  in  1  sole clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- load_en  in  1  write load_data to load_addr this cycle
- load_addr  in  ADDR_W  word address for the load
- load_data  in  DATA_W  word to store
- clear_req  in  1  start a sweep that zeroes the whole memory
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  word address to fetch
- fetch_ready  out  1  a fetch is accepted this cycle when fetch_req & fetch_ready
- fetch_valid  out  1  fetch_data and fetch_fault are valid
- fetch_data  out  DATA_W  fetched word
- fetch_fault  out  1  the fetched address was ≥ DEPTH
- busy  out  1  the clear sweep is in progress

## Operation
- FSM has two states, IDLE and CLEAR. Reset enters IDLE.
- IDLE → CLEAR when clear_req=1. A clear request wins over a load in the same cycle; that load is dropped.
- CLEAR state:
  - Writes 0 to address clr_ptr each cycle, starting at 0.
  - Moves to IDLE after writing DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
  - busy=1 for the whole of CLEAR.
  - clear_req is ignored while in CLEAR.
- fetch_ready = (state==IDLE) & ~load_en. A load blocks a fetch in the same cycle.
- Load port:
  - A load with load_addr ≥ DEPTH is silently dropped.
  - A load is ignored in CLEAR.
- Accepted fetch:
  - If fetch_addr < DEPTH: fetch_data = mem[fetch_addr], fetch_fault=0.
  - Otherwise: fetch_data=0, fetch_fault=1.
- A fetch that is presented while fetch_ready=0 is not accepted and produces no valid. The requester holds its request and retries.
- Memory contents are not reset. Words are undefined until loaded or cleared. The bench must clear or load before fetching.
- Fetches are fully pipelined: one accept per cycle, with results returned in order.

## Timing
- Reset values: fetch_valid=0, fetch_data=0, fetch_fault=0, busy=0, fetch_ready=1 (when load_en=0).
- Reset is honoured mid-sweep and mid-fetch:
  - The FSM returns to IDLE and clr_ptr to 0.
  - In-flight fetches are discarded and fetch_valid drops immediately.
  - Memory words already cleared stay cleared.
- Fetch latency: an accept in cycle T gives fetch_valid=1 in cycle T+READ_LAT, with data and fault aligned to it.
- fetch_valid is high for exactly one cycle per accept.
- Load-to-fetch: a load in cycle T is visible to a fetch accepted in cycle T+1 or later.
- Clear-to-fetch:
  - clear_req in cycle T puts CLEAR in cycles T+1 … T+DEPTH.
  - fetch_ready returns to 1 in cycle T+DEPTH+1.
  - Fetches accepted before CLEAR was entered still complete with the old data.

## Structure
- Shared package `instr_mem_pkg` holds:
  - state enum {ST_IDLE, ST_CLEAR}
  - default constants DATA_W, ADDR_W, DEPTH
- One sub-module, `imem_pipe`: a READ_LAT-deep valid/data/fault delay line with asynchronous reset on the valid bits. Stage 1 is the registered RAM read.
- RAM is a single-write, single-read array. The write mux selects the clear write over the load write.

## Test plan
- Reset, then load 0xDEADBEEF@3 and 0x12345678@4, then fetch 3 and 4 back-to-back. With READ_LAT=1: valid in the two following cycles, data DEADBEEF then 12345678, fault=0.
- Fetch address 300 with DEPTH=256 → fetch_valid after READ_LAT cycles, fetch_data=0, fetch_fault=1.
- load_en=1 and fetch_req=1 in the same cycle → fetch_ready=0 and no fetch_valid results; the fetch is accepted on the next cycle once load_en drops.
- Load 0xAAAA5555@10, then clear_req → busy=1 for exactly 256 cycles; a subsequent fetch of 10 returns 0.
- Assert rst during the sweep at clr_ptr≈100 → busy=0 and fetch_valid=0 immediately. After release, a fetch of 50 returns 0; a word loaded at 200 before the clear still holds its value.
- With READ_LAT=2, fetch addresses 0..7 on consecutive cycles → 8 consecutive valids starting 2 cycles after the first accept, in order.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and default sizes for the instruction memory controller.
package instr_mem_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_ADDR_W = 16;
    localparam int IMEM_DEPTH  = 256;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_pipe.sv
// Fetch result delay line; stage 0 captures the RAM read word.
module imem_pipe
    import instr_mem_pkg::*;
#(
    parameter int DATA_W   = IMEM_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_fault,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_fault
);

    logic [READ_LAT-1:0] vld;
    logic [READ_LAT-1:0] flt;
    logic [DATA_W-1:0]   dat [READ_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            flt <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            flt[0] <= in_fault;
            dat[0] <= in_data;
            for (int i = 1; i < READ_LAT; i++) begin
                vld[i] <= vld[i-1];
                flt[i] <= flt[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[READ_LAT-1];
    assign out_fault = flt[READ_LAT-1];
    assign out_data  = dat[READ_LAT-1];

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory: pipelined fetch port, program-load port
// and a clear sweep that zeroes every word.
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int DATA_W   = IMEM_DATA_W,
    parameter int ADDR_W   = IMEM_ADDR_W,
    parameter int DEPTH    = IMEM_DEPTH,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              clear_req,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    output logic              busy
);

    localparam int IDX_W = idx_width(DEPTH);
    // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_e           state;
    state_e           state_nxt;
    logic [IDX_W-1:0] clr_ptr;
    logic [IDX_W-1:0] clr_ptr_nxt;

    logic              we;
    logic [IDX_W-1:0]  wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              load_hit;
    logic              fetch_hit;
    logic              accept;
    logic              rd_valid;
    logic              rd_fault;
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        unique case (state)
            ST_IDLE: begin
                clr_ptr_nxt = '0;
                if (clear_req) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_ptr == LAST) begin
                    state_nxt   = ST_IDLE;
                    clr_ptr_nxt = '0;
                end else begin
                    clr_ptr_nxt = clr_ptr + 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                clr_ptr_nxt = '0;
            end
        endcase
    end

    assign busy        = (state == ST_CLEAR);
    assign fetch_ready = (state == ST_IDLE) & ~load_en;

    assign load_hit  = ({1'b0, load_addr} < DEPTH_X);
    assign fetch_hit = ({1'b0, fetch_addr} < DEPTH_X);

    // Sweep write has priority; a load racing clear_req is dropped.
    always_comb begin
        we = 1'b0;
        wa = clr_ptr;
        wd = '0;
        if (state == ST_CLEAR) begin
            we = 1'b1;
        end else if (load_en && !clear_req && load_hit) begin
            we = 1'b1;
            wa = load_addr[IDX_W-1:0];
            wd = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign accept   = fetch_req & fetch_ready;
    assign rd_valid = accept;
    assign rd_fault = accept & ~fetch_hit;

    always_comb begin
        rd_word = '0;
        if (accept && fetch_hit) begin
            rd_word = mem[fetch_addr[IDX_W-1:0]];
        end
    end

    imem_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid),
        .in_data   (rd_word),
        .in_fault  (rd_fault),
        .out_valid (fetch_valid),
        .out_data  (fetch_data),
        .out_fault (fetch_fault)
    );

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench: two instances (READ_LAT 1 and 2) share stimulus,
// each with its own expected-result queue.
module tb_instr_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [15:0] load_addr;
    logic [31:0] load_data;
    logic        clear_req;
    logic        fetch_req;
    logic [15:0] fetch_addr;

    logic [1:0]  rdy;
    logic [1:0]  vld;
    logic [1:0]  flt;
    logic [1:0]  bsy;
    logic [31:0] dat [2];

    typedef struct {
        logic [31:0] d;
        logic        f;
        int          c;
    } exp_t;

    exp_t        q [2][$];
    exp_t        mon_e;
    logic [31:0] model [256];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    instr_mem_ctrl #(.READ_LAT(1)) u_lat1 (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .clear_req   (clear_req),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (rdy[0]),
        .fetch_valid (vld[0]),
        .fetch_data  (dat[0]),
        .fetch_fault (flt[0]),
        .busy        (bsy[0])
    );

    instr_mem_ctrl #(.READ_LAT(2)) u_lat2 (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .clear_req   (clear_req),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (rdy[1]),
        .fetch_valid (vld[1]),
        .fetch_data  (dat[1]),
        .fetch_fault (flt[1]),
        .busy        (bsy[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result becomes visible READ_LAT cycles after the accept edge.
    task automatic push(input logic [15:0] a);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.f = (a >= 16'd256);
            e.d = e.f ? 32'h0 : model[a[7:0]];
            e.c = cyc + k + 1;
            q[k].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (vld[k]) begin
                    if (q[k].size() == 0) begin
                        chk($sformatf("u%0d_spurious_valid", k), 1, 0);
                    end else begin
                        mon_e = q[k].pop_front();
                        chk($sformatf("u%0d_data", k), dat[k], mon_e.d);
                        chk($sformatf("u%0d_fault", k), flt[k], mon_e.f);
                        chk($sformatf("u%0d_cycle", k), cyc, mon_e.c);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        load_en   = 1'b0;
        clear_req = 1'b0;
        fetch_req = 1'b0;
        rst       = 1'b1;
        q[0].delete();
        q[1].delete();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_u%0d_valid", tag, k), vld[k], 0);
            chk($sformatf("%s_u%0d_data", tag, k), dat[k], 0);
            chk($sformatf("%s_u%0d_fault", tag, k), flt[k], 0);
            chk($sformatf("%s_u%0d_busy", tag, k), bsy[k], 0);
            chk($sformatf("%s_u%0d_ready", tag, k), rdy[k], 1);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        if (a < 16'd256) model[a[7:0]] = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        #1;
        chk("fetch_ready_u0", rdy[0], 1);
        chk("fetch_ready_u1", rdy[1], 1);
        push(a);
        step();
        fetch_req = 1'b0;
    endtask

    task automatic start_clear();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
    endtask

    // Counts busy cycles; optionally pokes a load and a second clear
    // mid-sweep, both of which must be ignored.
    task automatic wait_sweep(input bit poke);
        int n;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bsy[0]) begin
                n++;
                chk("busy_match", bsy[1], 1);
            end else if (n > 0) begin
                break;
            end
            if (poke) begin
                load_en   = (n == 200);
                load_addr = 16'd7;
                load_data = 32'h0000_0777;
                clear_req = (n == 250);
            end
        end
        load_en   = 1'b0;
        clear_req = 1'b0;
        chk("busy_len", n, 256);
        chk("ready_after_clear", rdy[0], 1);
        for (int a = 0; a < 256; a++) model[a] = 32'h0;
    endtask

    initial begin
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        clear_req  = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        rst        = 1'b1;

        do_reset("reset");

        start_clear();
        wait_sweep(1'b1);
        step();
        fetch(16'd7);
        fetch(16'd255);

        load(16'd3, 32'hDEAD_BEEF);
        load(16'd4, 32'h1234_5678);
        fetch(16'd3);
        fetch(16'd4);

        load(16'd300, 32'hFFFF_FFFF);
        load(16'd255, 32'h0000_0FF0);
        fetch(16'd300);
        fetch(16'd256);
        fetch(16'd44);
        fetch(16'd255);

        load_en    = 1'b1;
        load_addr  = 16'd20;
        load_data  = 32'h0000_2020;
        fetch_req  = 1'b1;
        fetch_addr = 16'd20;
        #1;
        chk("blocked_ready_u0", rdy[0], 0);
        chk("blocked_ready_u1", rdy[1], 0);
        step();
        model[20] = 32'h0000_2020;
        load_en   = 1'b0;
        fetch(16'd20);

        load(16'd10, 32'hAAAA_5555);
        start_clear();
        wait_sweep(1'b0);
        step();
        fetch(16'd10);

        load(16'd200, 32'hCAFE_F00D);
        load(16'd150, 32'h0000_1500);
        clear_req = 1'b1;
        load_en   = 1'b1;
        load_addr = 16'd150;
        load_data = 32'h0000_0BAD;
        step();
        clear_req = 1'b0;
        load_en   = 1'b0;
        repeat (99) step();
        chk("mid_sweep_busy", bsy[0], 1);
        for (int a = 0; a < 99; a++) model[a] = 32'h0;
        do_reset("sweep_rst");
        fetch(16'd50);
        fetch(16'd200);
        fetch(16'd150);

        fetch(16'd3);
        chk("pre_rst_valid", vld[0], 1);
        do_reset("fetch_rst");

        for (int i = 0; i < 8; i++) begin
            load(16'(i), 32'h0000_0100 + 32'(i));
        end
        for (int i = 0; i < 8; i++) begin
            fetch(16'(i));
        end

        repeat (4) step();
        chk("drain_u0", q[0].size(), 0);
        chk("drain_u1", q[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
